// File: rtl/freq_meas_pkg.sv
// Shared types and helpers for the frequency meter measurement controller.
// Holds the sequencer state set, gate range codes and the gate-length calculation.
package freq_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_GATE,
        ST_EVAL,
        ST_LATCH,
        ST_HOLD
    } state_t;

    localparam logic [1:0] RANGE_1MS   = 2'd0;
    localparam logic [1:0] RANGE_10MS  = 2'd1;
    localparam logic [1:0] RANGE_100MS = 2'd2;
    localparam logic [1:0] RANGE_1S    = 2'd3;

    localparam int GATE_CALC_W = 32;

    // Gate length in ticks; callers truncate to their own timer width.
    function automatic logic [GATE_CALC_W-1:0] gate_ticks(input logic [1:0] rng,
                                                          input int     ticks_per_ms);
        logic [GATE_CALC_W-1:0] decades;
        case (rng)
            RANGE_1MS:   decades = 32'd1;
            RANGE_10MS:  decades = 32'd10;
            RANGE_100MS: decades = 32'd100;
            default:     decades = 32'd1000;
        endcase
        return GATE_CALC_W'(ticks_per_ms) * decades;
    endfunction

endpackage

// File: rtl/gate_sequencer_tick_timer.sv
// Loadable down-counter advanced by a tick enable, with a single-cycle done pulse.
// Shared by the gate interval and the display holdoff interval.
module tick_timer #(
    parameter int W = 20
) (
    input  logic         fpga_clk,
    input  logic         nreset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic         o_done
);

    logic [W-1:0] r_count;
    logic         r_armed;

    // Expires on the tick that consumes the last count; a zero load expires at once.
    assign o_done = r_armed && ((r_count == '0) || (i_tick && (r_count == W'(1))));

    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_armed <= 1'b1;
        end else if (r_armed) begin
            if (o_done)
                r_armed <= 1'b0;
            if (i_tick && (r_count != '0))
                r_count <= r_count - W'(1);
        end
    end

endmodule

// File: rtl/gate_sequencer.sv
// Measurement sequencer: clear counter, gate for the chosen range, latch, hold display.
// Auto-ranging steps down on counter overflow and up when the leading digits are empty.
module gate_sequencer
    import freq_meas_pkg::*;
#(
    parameter int TICKS_PER_MS  = 1000,
    parameter int HOLDOFF_TICKS = 100000,
    parameter int TMR_W         = 20
) (
    input  logic       fpga_clk,
    input  logic       nreset,
    input  logic       tick_1us,
    input  logic       run,
    input  logic       auto_range,
    input  logic [1:0] range_sel,
    input  logic       ctr_carry,
    input  logic       msd_zero,
    output logic       gate_en,
    output logic       clear_ctr,
    output logic       latch,
    output logic [1:0] range,
    output logic       overflow,
    output logic       busy
);

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_cur_range;
    logic       r_ovf_seen;
    logic [1:0] r_range;
    logic       r_overflow;

    logic             w_timer_load;
    logic [TMR_W-1:0] w_timer_val;
    logic [TMR_W-1:0] w_gate_load;
    logic             w_timer_tick;
    logic             w_timer_done;
    logic             w_range_down;
    logic             w_range_up;

    assign w_gate_load  = TMR_W'(gate_ticks(r_cur_range, TICKS_PER_MS));
    assign w_timer_load = (r_state == ST_CLEAR) || (r_state == ST_LATCH);
    assign w_timer_val  = (r_state == ST_CLEAR) ? w_gate_load : TMR_W'(HOLDOFF_TICKS);
    assign w_timer_tick = tick_1us && ((r_state == ST_GATE) || (r_state == ST_HOLD));

    // Overflow on a slower range retries one decade faster instead of latching.
    assign w_range_down = auto_range && r_ovf_seen && (r_cur_range != RANGE_1MS);
    assign w_range_up   = auto_range && !r_ovf_seen && msd_zero && (r_cur_range != RANGE_1S);

    tick_timer #(
        .W(TMR_W)
    ) u_timer (
        .fpga_clk   (fpga_clk),
        .nreset     (nreset),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .i_tick     (w_timer_tick),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (run) w_state_next = ST_CLEAR;
            ST_CLEAR: w_state_next = ST_GATE;
            ST_GATE:  if (w_timer_done) w_state_next = ST_EVAL;
            ST_EVAL:  w_state_next = w_range_down ? ST_CLEAR : ST_LATCH;
            ST_LATCH: w_state_next = ST_HOLD;
            ST_HOLD:  if (w_timer_done) w_state_next = run ? ST_CLEAR : ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        gate_en   = (r_state == ST_GATE);
        clear_ctr = (r_state == ST_CLEAR);
        latch     = (r_state == ST_LATCH);
        busy      = (r_state != ST_IDLE);
        range     = r_range;
        overflow  = r_overflow;
    end

    always_ff @(posedge fpga_clk or negedge nreset) begin
        if (!nreset) begin
            r_cur_range <= RANGE_1S;
            r_ovf_seen  <= 1'b0;
            r_range     <= RANGE_1S;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  if (run && !auto_range) r_cur_range <= range_sel;
                ST_CLEAR: r_ovf_seen <= 1'b0;
                ST_GATE:  if (ctr_carry) r_ovf_seen <= 1'b1;
                ST_EVAL:  if (w_range_down) r_cur_range <= r_cur_range - 2'd1;
                ST_LATCH: begin
                    r_range    <= r_cur_range;
                    r_overflow <= r_ovf_seen;
                    if (w_range_up)
                        r_cur_range <= r_cur_range + 2'd1;
                end
                ST_HOLD:  if (w_timer_done && run && !auto_range) r_cur_range <= range_sel;
                default:  r_ovf_seen <= r_ovf_seen;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Randomized bench for gate_sequencer against a timeline model of one measurement cycle.
// Directed scenarios pin gate lengths, latched ranges and reset behaviour with literal values.
module tb_gate_sequencer;

    localparam int TPM  = 10;
    localparam int HOLD = 5;
    localparam int TW   = 20;

    localparam int K_LATCH = 0;
    localparam int K_GATE  = 1;
    localparam int K_IDLE  = 2;

    logic       fpga_clk = 1'b0;
    logic       nreset;
    logic       tick_1us;
    logic       run;
    logic       auto_range;
    logic [1:0] range_sel;
    logic       ctr_carry;
    logic       msd_zero;
    logic       gate_en;
    logic       clear_ctr;
    logic       latch;
    logic [1:0] range;
    logic       overflow;
    logic       busy;

    gate_sequencer #(
        .TICKS_PER_MS  (TPM),
        .HOLDOFF_TICKS (HOLD),
        .TMR_W         (TW)
    ) dut (
        .fpga_clk   (fpga_clk),
        .nreset     (nreset),
        .tick_1us   (tick_1us),
        .run        (run),
        .auto_range (auto_range),
        .range_sel  (range_sel),
        .ctr_carry  (ctr_carry),
        .msd_zero   (msd_zero),
        .gate_en    (gate_en),
        .clear_ctr  (clear_ctr),
        .latch      (latch),
        .range      (range),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_assert++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic int pow10(input int r);
        int v = 1;
        repeat (r) v = v * 10;
        return v;
    endfunction

    // ---------------- behavioural model ----------------
    int exp_gate, exp_clr, exp_lat, exp_busy, exp_range, exp_ovf;
    int m_cur;
    bit m_abort;

    task automatic set_exp(input int g, input int c, input int l, input int b);
        exp_gate = g; exp_clr = c; exp_lat = l; exp_busy = b;
    endtask

    task automatic model_reset();
        set_exp(0, 0, 0, 0);
        exp_range = 3;
        exp_ovf   = 0;
        m_cur     = 3;
    endtask

    task automatic m_step();
        @(posedge fpga_clk or negedge nreset);
        if (!nreset) m_abort = 1'b1;
    endtask

    // One pass: idle until run, then measurement cycles until run is low at holdoff end.
    task automatic model_run();
        int n;
        int cnt;
        bit ovf_s;
        set_exp(0, 0, 0, 0);
        forever begin
            m_step(); if (m_abort) return;
            if (run) break;
        end
        if (!auto_range) m_cur = range_sel;
        forever begin
            set_exp(0, 1, 0, 1);
            m_step(); if (m_abort) return;
            n = TPM * pow10(m_cur);
            ovf_s = 1'b0;
            cnt = 0;
            set_exp(1, 0, 0, 1);
            while (cnt < n) begin
                m_step(); if (m_abort) return;
                if (ctr_carry) ovf_s = 1'b1;
                if (tick_1us) cnt++;
            end
            set_exp(0, 0, 0, 1);
            m_step(); if (m_abort) return;
            if (auto_range && ovf_s && m_cur > 0) begin
                m_cur--;
                continue;
            end
            set_exp(0, 0, 1, 1);
            m_step(); if (m_abort) return;
            exp_range = m_cur;
            exp_ovf   = ovf_s;
            if (auto_range && !ovf_s && msd_zero && m_cur < 3) m_cur++;
            set_exp(0, 0, 0, 1);
            cnt = 0;
            do begin
                m_step(); if (m_abort) return;
                if (tick_1us) cnt++;
            end while (cnt < HOLD);
            if (!run) return;
            if (!auto_range) m_cur = range_sel;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            wait (nreset === 1'b1);
            m_abort = 1'b0;
            model_run();
            if (m_abort) model_reset();
        end
    end

    // ---------------- compare and monitor ----------------
    int cyc = 0;
    int glen = 0;
    int last_gate = 0;
    int n_clears = 0;
    bit lat_prev = 1'b0;
    int gate_lens[$];
    int lat_ranges[$];
    int lat_ovfs[$];
    int lat_gaps[$];

    always @(negedge fpga_clk) begin
        cyc++;
        chk("gate_en",   gate_en,   exp_gate);
        chk("clear_ctr", clear_ctr, exp_clr);
        chk("latch",     latch,     exp_lat);
        chk("busy",      busy,      exp_busy);
        chk("range",     range,     exp_range);
        chk("overflow",  overflow,  exp_ovf);
        if (gate_en) begin
            glen++;
            last_gate = cyc;
        end else if (glen > 0) begin
            gate_lens.push_back(glen);
            glen = 0;
        end
        if (clear_ctr) n_clears++;
        if (lat_prev) begin
            lat_ranges.push_back(range);
            lat_ovfs.push_back(overflow);
        end
        if (latch) lat_gaps.push_back(cyc - last_gate);
        lat_prev = latch;
    end

    task automatic clear_mon();
        gate_lens.delete();
        lat_ranges.delete();
        lat_ovfs.delete();
        lat_gaps.delete();
        n_clears = 0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // ---------------- stimulus ----------------
    int tick_pct = 100;
    int carry_mode = 0;
    int shot_delay = 0;
    bit shot_armed = 1'b0;

    initial begin
        tick_1us  = 1'b0;
        ctr_carry = 1'b0;
        forever begin
            @(posedge fpga_clk); #2;
            tick_1us = (tick_pct >= 100) || ($urandom_range(0, 99) < tick_pct);
            case (carry_mode)
                1: ctr_carry = ($urandom_range(0, 299) == 0);
                2: begin
                    ctr_carry = 1'b0;
                    if (gate_en && shot_armed) begin
                        if (shot_delay == 0) begin
                            ctr_carry  = 1'b1;
                            shot_armed = 1'b0;
                        end else begin
                            shot_delay--;
                        end
                    end
                end
                3: ctr_carry = gate_en;
                default: ctr_carry = 1'b0;
            endcase
        end
    end

    task automatic cyc_n(input int n);
        repeat (n) @(posedge fpga_clk);
        #2;
    endtask

    task automatic wait_for(input string nm, input int kind, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge fpga_clk);
            case (kind)
                K_LATCH: hit = (latch === 1'b1);
                K_GATE:  hit = (gate_en === 1'b1);
                default: hit = (busy === 1'b0);
            endcase
        end
        n_assert++;
        if (!hit) begin
            n_fail++;
            $display("FAIL %s: event not seen within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        nreset = 1'b0; run = 1'b0; auto_range = 1'b0; range_sel = 2'd0; msd_zero = 1'b0;
        cyc_n(3);
        chk("rst_gate_en", gate_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_range", range, 3);
        chk("rst_overflow", overflow, 0);
        nreset = 1'b1;
        cyc_n(2);

        // Manual 10 ms gate
        range_sel = 2'd1; run = 1'b1; clear_mon();
        wait_for("s2_latch", K_LATCH, 500);
        cyc_n(1); run = 1'b0;
        @(negedge fpga_clk);
        chk("s2_range", range, 1);
        chk("s2_overflow", overflow, 0);
        wait_for("s2_idle", K_IDLE, 50);
        cyc_n(5);
        chk("s2_gate_len", q_at(gate_lens, 0), 100);
        chk("s2_latch_gap", q_at(lat_gaps, 0), 2);
        chk("s2_clears", n_clears, 1);

        // Auto from reset: one carry in the 1 s gate, clean 100 ms gate
        nreset = 1'b0; cyc_n(2); nreset = 1'b1;
        auto_range = 1'b1; msd_zero = 1'b0; clear_mon();
        shot_delay = $urandom_range(100, 5000); shot_armed = 1'b1; carry_mode = 2;
        run = 1'b1;
        wait_for("s3_latch", K_LATCH, 12000);
        cyc_n(1); run = 1'b0; carry_mode = 0;
        @(negedge fpga_clk);
        chk("s3_range", range, 2);
        wait_for("s3_idle", K_IDLE, 50);
        cyc_n(2);
        chk("s3_n_gates", gate_lens.size(), 2);
        chk("s3_gate0", q_at(gate_lens, 0), 10000);
        chk("s3_gate1", q_at(gate_lens, 1), 1000);
        chk("s3_n_latch", lat_ranges.size(), 1);

        // Auto with overflow on every range down to 1 ms
        carry_mode = 3; run = 1'b1; clear_mon();
        wait_for("s4_latch", K_LATCH, 3000);
        cyc_n(1); run = 1'b0; carry_mode = 0;
        wait_for("s4_idle", K_IDLE, 50);
        cyc_n(2);
        chk("s4_range", q_at(lat_ranges, 0), 0);
        chk("s4_overflow", q_at(lat_ovfs, 0), 1);
        chk("s4_n_latch", lat_ranges.size(), 1);
        chk("s4_gate2", q_at(gate_lens, 2), 10);

        // Auto range up with msd_zero
        msd_zero = 1'b1; run = 1'b1; clear_mon();
        wait_for("s5_latch_a", K_LATCH, 100);
        wait_for("s5_latch_b", K_LATCH, 300);
        wait_for("s5_gate_c", K_GATE, 50);
        cyc_n(1); run = 1'b0;
        wait_for("s5_idle", K_IDLE, 2000);
        cyc_n(2);
        chk("s5_range0", q_at(lat_ranges, 0), 0);
        chk("s5_range1", q_at(lat_ranges, 1), 1);
        chk("s5_range2", q_at(lat_ranges, 2), 2);
        chk("s5_gate2", q_at(gate_lens, 2), 1000);

        // run dropped mid-gate
        auto_range = 1'b0; msd_zero = 1'b0; range_sel = 2'd2; run = 1'b1; clear_mon();
        wait_for("s6_gate", K_GATE, 20);
        cyc_n(500); run = 1'b0;
        wait_for("s6_idle", K_IDLE, 1200);
        cyc_n(50);
        chk("s6_clears", n_clears, 1);
        chk("s6_n_latch", lat_ranges.size(), 1);
        chk("s6_gate_len", q_at(gate_lens, 0), 1000);

        // Reset mid-gate, then a full restart
        run = 1'b1;
        wait_for("s7_gate", K_GATE, 20);
        cyc_n(300);
        @(posedge fpga_clk); #3;
        nreset = 1'b0;
        #1;
        chk("s7_gate_en", gate_en, 0);
        chk("s7_busy", busy, 0);
        chk("s7_range", range, 3);
        cyc_n(2);
        nreset = 1'b1; clear_mon();
        wait_for("s7_latch", K_LATCH, 2000);
        cyc_n(1); run = 1'b0;
        wait_for("s7_idle", K_IDLE, 50);
        cyc_n(2);
        chk("s7_gate_len", q_at(gate_lens, 0), 1000);
        chk("s7_range_latched", q_at(lat_ranges, 0), 2);

        // Random phase, checked cycle by cycle against the model
        for (int s = 0; s < 40; s++) begin
            tick_pct   = ($urandom_range(0, 3) == 0) ? 60 : 100;
            carry_mode = $urandom_range(0, 1);
            auto_range = 1'($urandom_range(0, 1));
            range_sel  = 2'($urandom_range(0, 2));
            msd_zero   = 1'($urandom_range(0, 1));
            run        = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                @(posedge fpga_clk); #3;
                nreset = 1'b0;
                cyc_n(2);
                nreset = 1'b1;
            end
            cyc_n($urandom_range(20, 400));
        end
        run = 1'b0; carry_mode = 0; tick_pct = 100;
        wait_for("rand_idle", K_IDLE, 30000);
        cyc_n(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sequencer.md
Name: gate_sequencer

Overview:
- Measurement controller for the frequency meter datapath.
- Sequences each measurement cycle: clear BCD counter → open gate for the selected time → latch result → display holdoff.
- Gate time is selectable or auto-ranged: 1 ms / 10 ms / 100 ms / 1 s, driven by counter overflow and leading-digit status.
- Sits between the 1 MHz timebase prescaler and the 8-digit BCD counter. Replaces the fixed 1 s gate logic.

Parameters:
- TICKS_PER_MS, 1000, tick_1us pulses per millisecond of gate.
- HOLDOFF_TICKS, 100000, tick_1us pulses of display hold after each latch.
- TMR_W, 20, width of gate/holdoff tick counter. Must hold 1000*TICKS_PER_MS and HOLDOFF_TICKS.

Ports:
- fpga_clk  in  1  system clock.
- nreset  in  1  asynchronous active-low reset.
- tick_1us  in  1  one-fpga_clk-cycle enable pulse at 1 MHz from the prescaler.
- run  in  1  level; 1 = continuous measurement, 0 = stop after the current cycle.
- auto_range  in  1  1 = automatic range select; 0 = use range_sel.
- range_sel  in  2  manual gate: 0=1 ms, 1=10 ms, 2=100 ms, 3=1 s.
- ctr_carry  in  1  BCD counter carry_out (count passed 99999999), sampled while gating.
- msd_zero  in  1  1 when the top 4 BCD digits are zero (result uses fewer than 5 digits).
- gate_en  out  1  high while gating; ANDed with the edge-detect enable of the counter.
- clear_ctr  out  1  one-cycle synchronous clear of the counter.
- latch  out  1  one-cycle transfer of count to the display registers.
- range  out  2  gate range of the latched result; drives decimal-point placement.
- overflow  out  1  latched result overflowed on the 1 ms range (display "OFL").
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values: state=IDLE, all pulse outputs 0, gate_en=0, range=3, overflow=0, busy=0, timer=0, cur_range=3.
- FSM states: IDLE, CLEAR, GATE, EVAL, LATCH, HOLD.
- IDLE
  - If run=1: cur_range = auto_range ? cur_range : range_sel; go to CLEAR.
- CLEAR (1 cycle)
  - clear_ctr=1, timer loads gate length, ovf_seen cleared.
  - Next: GATE.
- GATE
  - gate_en=1.
  - Timer decrements on each tick_1us. Any fpga_clk cycle with ctr_carry=1 sets ovf_seen.
  - The tick on which timer reaches 1 ends the gate. gate_en drops the next cycle.
  - Gate length = TICKS_PER_MS * 10^cur_range ticks; exact tick count, no off-by-one.
  - Next: EVAL.
- EVAL (1 cycle), priority order:
  - a) auto_range=1, ovf_seen=1, cur_range>0 → cur_range-1, go to CLEAR. No latch.
  - b) otherwise → LATCH.
- LATCH (1 cycle)
  - latch=1, range<=cur_range, overflow<=ovf_seen.
  - If auto_range=1, ovf_seen=0, msd_zero=1, cur_range<3 → cur_range+1, applied to the next cycle only.
  - Timer loads HOLDOFF_TICKS. Next: HOLD.
- HOLD
  - Timer decrements on tick_1us. At expiry: run=1 → CLEAR, run=0 → IDLE.
  - HOLDOFF_TICKS=0 exits on the first cycle.
- run deasserted mid-cycle: current measurement completes and latches; no abort.
- Manual mode: range_sel is sampled only when leaving IDLE or HOLD. Changes during GATE do not affect the current gate.
- Simultaneous ctr_carry and final gate tick: carry is counted (ovf_seen=1).
- Auto-range hysteresis is inherent: range up needs msd_zero, range down needs overflow. Factor-of-10 spacing prevents oscillation.
- clear_ctr and latch are never asserted in the same cycle. latch always precedes the next clear_ctr by at least 1 cycle.
- Async reset mid-GATE returns to IDLE immediately with all outputs at reset values.
- tick_1us held high continuously is legal: gate length counts in fpga_clk cycles.

Decomposition:
- Shared package freq_meas_pkg:
  - state enum (6 states).
  - range encoding constants RANGE_1MS..RANGE_1S.
  - function gate_ticks(range, TICKS_PER_MS) returning the TMR_W-bit load value.
- One natural sub-module: tick_timer. Loadable down-counter with tick enable and a one-cycle done output, reused for gate and holdoff.

Test Plan:
- Manual range_sel=1, TICKS_PER_MS=10, HOLDOFF_TICKS=5, tick every cycle, run=1 → clear_ctr pulse, gate_en high exactly 100 cycles, latch 2 cycles after gate_en falls, range=1, overflow=0.
- auto_range=1 from reset, ctr_carry pulsed during the 1 s gate → no latch; next gate is 100 ms. Clean at 100 ms → latch with range=2.
- auto_range=1, ctr_carry on every range down to 0 → single latch with range=0, overflow=1.
- auto_range=1, range=1, msd_zero=1 at LATCH → latch range=1; next gate_en length corresponds to range 2.
- run dropped at gate midpoint → gate finishes, latch pulses, HOLD expires, IDLE, busy=0, no further clear_ctr.
- nreset asserted during GATE → gate_en=0, busy=0, range=3 within the same cycle. Restart on run produces a full-length gate.
